hpm_sample_sequencer: RTL



---
 rtl/hpm_sample_sequencer_pkg.sv | 29 ++
 rtl/hpm_sample_sequencer_fifo.sv | 64 ++++++
 rtl/hpm_sample_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hpm_sample_sequencer_pkg.sv
// Shared types and constants for the HPM sample sequencer.
//   XLEN               : CSR / counter data width
//   MHPMCounterNum     : number of generic hardware performance counters
//   CSR_MHPM_*_3       : CSR addresses of the first generic counter / event selector
//   hpm_smp_state_e    : sequencer FSM states
//   hpm_sample_t       : one FIFO entry {idx, data, last} for the default counter count
package hpm_sample_sequencer_pkg;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned MHPMCounterNum = 6;

  localparam logic [11:0] CSR_MHPM_EVENT_3   = 12'h323;
  localparam logic [11:0] CSR_MHPM_COUNTER_3 = 12'hB03;

  localparam int unsigned HpmIdxWidth = (MHPMCounterNum > 1) ? $clog2(MHPMCounterNum) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SCAN = 2'd2
  } hpm_smp_state_e;

  typedef struct packed {
    logic [HpmIdxWidth-1:0] idx;
    logic [XLEN-1:0]        data;
    logic                   last;
  } hpm_sample_t;

endpackage

// File: rtl/hpm_sample_sequencer_fifo.sv
// Small synchronous FIFO for sample entries. Not fall-through: a pushed word
// becomes visible at data_o on the cycle after the push. A push while full is
// dropped even if a pop happens in the same cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and word
//   pop_i         : remove head (ignored when empty)
//   full_o/empty_o: occupancy flags
//   data_o        : head word, forced to zero while empty
module hpm_sample_sequencer_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DataWidth-1:0] data_o
);

  localparam int unsigned AddrWidth = $clog2(Depth);
  localparam logic [AddrWidth:0] CountFull = Depth[AddrWidth:0];

  logic [DataWidth-1:0] mem_reg [Depth];
  logic [AddrWidth-1:0] wr_ptr_reg;
  logic [AddrWidth-1:0] rd_ptr_reg;
  logic [AddrWidth:0]   count_reg;
  logic                 do_push;
  logic                 do_pop;

  assign full_o  = (count_reg == CountFull);
  assign empty_o = (count_reg == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage carries no reset so it maps onto plain RAM/registers.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AddrWidth'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AddrWidth'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AddrWidth+1)'(1);
        2'b01:   count_reg <= count_reg - (AddrWidth+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Gating with empty keeps the outputs at zero after reset.
  assign data_o = empty_o ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/hpm_sample_sequencer.sv
// Periodic HPM counter sampler and counter-port arbiter. The CSR file always
// owns the counter port when it requests it; otherwise a scan engine walks the
// enabled counters once per period and queues {idx, value, last} samples.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   csr_*                  : CSR file side of the counter port
//   pc_*                   : counter block port (pc_rdata_i combinational on pc_addr_o)
//   sample_en_i, period_i  : sampling enable and period (0 behaves as 1)
//   counter_mask_i         : counters included in a scan
//   smp_*                  : sample stream, valid/ready
//   overrun_o, clear_overrun_i : sticky dropped-tick flag and its clear
//   busy_o                 : a scan is in progress
module hpm_sample_sequencer
  import hpm_sample_sequencer_pkg::*;
#(
  parameter int unsigned NumCounters = MHPMCounterNum,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned PeriodWidth = 32,
  localparam int unsigned IdxWidth   = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   csr_req_i,
  input  logic [11:0]            csr_addr_i,
  input  logic                   csr_we_i,
  input  logic [XLEN-1:0]        csr_wdata_i,
  output logic [XLEN-1:0]        csr_rdata_o,
  output logic [11:0]            pc_addr_o,
  output logic                   pc_we_o,
  output logic [XLEN-1:0]        pc_wdata_o,
  input  logic [XLEN-1:0]        pc_rdata_i,
  input  logic                   sample_en_i,
  input  logic [PeriodWidth-1:0] period_i,
  input  logic [NumCounters-1:0] counter_mask_i,
  output logic                   smp_valid_o,
  input  logic                   smp_ready_i,
  output logic [IdxWidth-1:0]    smp_idx_o,
  output logic [XLEN-1:0]        smp_data_o,
  output logic                   smp_last_o,
  output logic                   overrun_o,
  input  logic                   clear_overrun_i,
  output logic                   busy_o
);

  localparam int unsigned        SmpWidth = IdxWidth + XLEN + 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumCounters - 1);

  hpm_smp_state_e         state_reg;
  logic [PeriodWidth-1:0] timer_reg;
  logic [PeriodWidth-1:0] reload_val;
  logic [IdxWidth-1:0]    k_reg;
  logic                   busy_reg;
  logic                   overrun_reg;

  logic                   in_scan;
  logic                   timer_zero;
  logic                   mask_bit;
  logic                   last_bit;
  logic [NumCounters-1:0] mask_above;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   resolve;
  logic                   push;
  logic                   overrun_set;
  logic [11:0]            scan_addr;
  logic [SmpWidth-1:0]    push_data;
  logic [SmpWidth-1:0]    head_data;

  // Period 0 is treated as 1, i.e. a reload value of 0.
  assign reload_val = (period_i == '0) ? '0 : period_i - PeriodWidth'(1);

  assign in_scan    = (state_reg == SCAN);
  assign timer_zero = (timer_reg == '0);
  assign mask_bit   = counter_mask_i[k_reg];

  // k is the last sample of the scan when no higher mask bit is set.
  assign mask_above = (counter_mask_i >> k_reg) >> 1;
  assign last_bit   = (mask_above == '0);

  // An index is resolved when it is skipped or pushed; CSR traffic and a full
  // FIFO (for an enabled counter) hold the index.
  assign resolve     = in_scan & ~csr_req_i & (~mask_bit | ~fifo_full);
  assign push        = resolve & mask_bit & sample_en_i;
  assign overrun_set = in_scan & sample_en_i & timer_zero;

  // Counter port mux: CSR file has absolute priority, scan engine is read-only.
  assign scan_addr   = in_scan ? (CSR_MHPM_COUNTER_3 + 12'(k_reg)) : 12'h000;
  assign pc_addr_o   = csr_req_i ? csr_addr_i : scan_addr;
  assign pc_we_o     = csr_req_i & csr_we_i;
  assign pc_wdata_o  = csr_wdata_i;
  assign csr_rdata_o = pc_rdata_i;

  assign push_data = {k_reg, pc_rdata_i, last_bit};

  hpm_sample_sequencer_fifo #(
    .DataWidth (SmpWidth),
    .Depth     (FifoDepth)
  ) i_smp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (smp_ready_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (head_data)
  );

  assign smp_valid_o = ~fifo_empty;
  assign {smp_idx_o, smp_data_o, smp_last_o} = head_data;
  assign busy_o      = busy_reg;
  assign overrun_o   = overrun_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      k_reg       <= '0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      // A new drop beats a simultaneous clear.
      overrun_reg <= overrun_set | (overrun_reg & ~clear_overrun_i);
      if (!sample_en_i) begin
        // Abandon any partial scan; queued samples stay in the FIFO.
        state_reg <= IDLE;
        k_reg     <= '0;
        busy_reg  <= 1'b0;
      end else begin
        unique case (state_reg)
          IDLE: begin
            state_reg <= WAIT;
            timer_reg <= reload_val;
          end
          WAIT: begin
            if (timer_zero) begin
              state_reg <= SCAN;
              timer_reg <= reload_val;
              k_reg     <= '0;
              busy_reg  <= 1'b1;
            end else begin
              timer_reg <= timer_reg - PeriodWidth'(1);
            end
          end
          SCAN: begin
            // The timer keeps running; an expiry here is a dropped tick.
            timer_reg <= timer_zero ? reload_val : timer_reg - PeriodWidth'(1);
            if (resolve) begin
              if (k_reg == LastIdx) begin
                state_reg <= WAIT;
                k_reg     <= '0;
                busy_reg  <= 1'b0;
              end else begin
                k_reg <= k_reg + IdxWidth'(1);
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
